// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection; 1-cycle ID->EX latency.
// Backpressure: a load-use stall holds PC and IF/ID for one cycle and injects one bubble; flush overrides the stall.
module id_ex_stage_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_MemToReg,
  input  logic             id_ALUSrc,
  input  logic             id_Branch,
  input  logic [3:0]       id_ALUOp,
  output logic             ID_EX_valid,
  output logic [XLEN-1:0]  ID_EX_pc,
  output logic [XLEN-1:0]  ID_EX_rs1_data,
  output logic [XLEN-1:0]  ID_EX_rs2_data,
  output logic [XLEN-1:0]  ID_EX_imm,
  output logic [4:0]       ID_EX_rs1,
  output logic [4:0]       ID_EX_rs2,
  output logic [4:0]       ID_EX_rd,
  output logic             ID_EX_RegWrite,
  output logic             ID_EX_MemRead,
  output logic             ID_EX_MemWrite,
  output logic             ID_EX_MemToReg,
  output logic             ID_EX_ALUSrc,
  output logic             ID_EX_Branch,
  output logic [3:0]       ID_EX_ALUOp,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic [CNT_W-1:0] stall_count
);

  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic stall;
  logic bubble;

  // Only the instruction directly behind a load is checked; older producers are forwarded.
  assign rs1_hit  = id_uses_rs1 & (id_rs1 == ID_EX_rd);
  assign rs2_hit  = id_uses_rs2 & (id_rs2 == ID_EX_rd);
  assign load_use = ID_EX_valid & ID_EX_MemRead & (ID_EX_rd != 5'd0) & id_valid
                    & (rs1_hit | rs2_hit);
  assign stall    = load_use & ~flush;
  assign bubble   = flush | stall;

  // Before the first reset edge the registers are unknown, so reset forces the holds open.
  assign PCWrite     = rst | ~stall;
  assign IF_ID_Write = rst | ~stall;

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ID_EX_valid    <= 1'b0;
      ID_EX_pc       <= '0;
      ID_EX_rs1_data <= '0;
      ID_EX_rs2_data <= '0;
      ID_EX_imm      <= '0;
      ID_EX_rs1      <= 5'd0;
      ID_EX_rs2      <= 5'd0;
      ID_EX_rd       <= 5'd0;
      ID_EX_RegWrite <= 1'b0;
      ID_EX_MemRead  <= 1'b0;
      ID_EX_MemWrite <= 1'b0;
      ID_EX_MemToReg <= 1'b0;
      ID_EX_ALUSrc   <= 1'b0;
      ID_EX_Branch   <= 1'b0;
      ID_EX_ALUOp    <= 4'd0;
    end else begin
      ID_EX_valid    <= id_valid;
      ID_EX_pc       <= id_pc;
      ID_EX_rs1_data <= id_rs1_data;
      ID_EX_rs2_data <= id_rs2_data;
      ID_EX_imm      <= id_imm;
      ID_EX_rs1      <= id_rs1;
      ID_EX_rs2      <= id_rs2;
      ID_EX_rd       <= id_rd;
      // An invalid slot carries its fields but must never write state.
      ID_EX_RegWrite <= id_valid & id_RegWrite;
      ID_EX_MemRead  <= id_valid & id_MemRead;
      ID_EX_MemWrite <= id_valid & id_MemWrite;
      ID_EX_MemToReg <= id_valid & id_MemToReg;
      ID_EX_ALUSrc   <= id_valid & id_ALUSrc;
      ID_EX_Branch   <= id_valid & id_Branch;
      ID_EX_ALUOp    <= id_valid ? id_ALUOp : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule
